branch_redirect_unit: RTL and testbench
=======================================

# branch_redirect_unit

Parametrised branch-misprediction redirect unit for the superscalar pipeline. It takes resolved branch outcomes from all Execute-stage lanes and picks the oldest mispredicted branch. It computes the corrected fetch PC for both the taken and the not-taken mispredict direction, squashes younger lanes in the same bundle, and holds a registered redirect request until Fetch accepts it. It generalises the two-lane combinational PC correction to N lanes with a valid/ready handshake and optional mispredict statistics.

## Interface
- LANES, 2, number of Execute-stage lanes; lane 0 is oldest in program order
- PC_W, 11, PC width in bits
- CNT_W, 16, mispredict counter width (used only with stats enabled)

- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- ex_valid  in  LANES  lane holds a live instruction
- ex_is_branch  in  LANES  lane instruction is a conditional branch
- ex_pred_taken  in  LANES  direction predicted at Fetch
- ex_taken  in  LANES  resolved direction
- ex_fallthru  in  LANES*PC_W  sequential PC after the branch; lane i at bits [i*PC_W +: PC_W]
- ex_target  in  LANES*PC_W  branch target address, packed as ex_fallthru
- redir_ready  in  1  Fetch accepts the redirect this cycle
- kill_younger  out  LANES  combinational squash mask for the current Execute bundle
- redir_valid  out  1  redirect request pending
- redir_pc  out  PC_W  corrected fetch PC
- redir_lane  out  $clog2(LANES) (min 1)  lane index of the winning branch
- flush  out  1  one-cycle pulse: flush all front-end stages
- mispredict_count  out  CNT_W  saturating count of accepted mispredicts

## Operation
- Per lane: mis[i] = ex_valid[i] & ex_is_branch[i] & (ex_pred_taken[i] != ex_taken[i]).
- Corrected PC[i] = ex_taken[i] ? ex_target[i] : ex_fallthru[i]. This covers both mispredict directions.
- Winner = lowest i with mis[i]=1. Higher lanes are younger and on the wrong path.
- kill_younger[j] = 1 for every j > winner, combinationally, when a winner exists and redir_valid=0. Otherwise it is all-zero.
- Two states: IDLE (redir_valid=0) and PEND (redir_valid=1).
- IDLE, any mis: next cycle enters PEND. Captures redir_pc = corrected PC[winner] and redir_lane = winner. Pulses flush for exactly that cycle. Increments the counter.
- IDLE, no mis: stays in IDLE.
- PEND, redir_ready=0: holds redir_pc and redir_lane stable.
- PEND, redir_ready=1: returns to IDLE next cycle.
- While redir_valid=1, including the acceptance cycle, all Execute inputs are wrong-path. mis is ignored and kill_younger stays 0.
- Lanes with ex_valid=0 or ex_is_branch=0 never mispredict, whatever their other inputs.
- Counter saturates at 2^CNT_W-1 and does not wrap.

## Timing
- Detect-to-redir_valid latency is 1 cycle. flush is high in the first PEND cycle only.
- kill_younger has zero latency, valid in the detect cycle.
- Minimum redirect occupancy is 1 cycle, when redir_ready is already high.
- A new detection is possible in the cycle after acceptance, i.e. the first IDLE cycle.
- Reset values: redir_valid=0, redir_pc=0, redir_lane=0, flush=0, mispredict_count=0. kill_younger follows its inputs combinationally.
- rst during PEND drops the request next edge with no flush. rst has priority over detect.

## Configuration
- BRU_STATS_EN defined: mispredict_count is a CNT_W-bit saturating register, incremented on each IDLE->PEND transition.
- BRU_STATS_EN undefined: no counter logic; mispredict_count is tied to 0.

## Test plan
- LANES=2, PC_W=11. Lane0 branch, pred=0, taken=1, target=0x155, redir_ready=1. Expect: kill_younger=2'b10 that cycle; next cycle redir_valid=1, redir_pc=0x155, redir_lane=0, flush=1; then IDLE.
- Lane1 only: pred=1, taken=0, fallthru=0x042. Expect: kill_younger=0; redir_pc=0x042, redir_lane=1.
- Both lanes mispredict with distinct targets. Expect: lane 0 wins; lane 1 killed; count +1 only.
- redir_ready=0 for 3 cycles, with new mispredicts on the inputs. Expect: redir_pc held; flush high first cycle only; no kill; count unchanged; IDLE one cycle after redir_ready=1.
- Correct predictions, ex_valid=0 with pred!=taken, and ex_is_branch=0. Expect: no redirect, no kill.
- rst asserted mid-PEND. Expect: all outputs 0 next cycle. With BRU_STATS_EN and CNT_W=2, four mispredicts leave count=3.

Source files
------------

// File: rtl/branch_redirect_unit.sv
// Branch-misprediction redirect unit: picks the oldest mispredicted lane, squashes younger
// lanes and holds a registered redirect until Fetch accepts it. BRU_STATS_EN adds a counter.
module branch_redirect_unit #(
    parameter int LANES = 2,
    parameter int PC_W  = 11,
    parameter int CNT_W = 16,
    localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LANES-1:0]      ex_valid,
    input  logic [LANES-1:0]      ex_is_branch,
    input  logic [LANES-1:0]      ex_pred_taken,
    input  logic [LANES-1:0]      ex_taken,
    input  logic [LANES*PC_W-1:0] ex_fallthru,
    input  logic [LANES*PC_W-1:0] ex_target,
    input  logic                  redir_ready,
    output logic [LANES-1:0]      kill_younger,
    output logic                  redir_valid,
    output logic [PC_W-1:0]       redir_pc,
    output logic [LW-1:0]         redir_lane,
    output logic                  flush,
    output logic [CNT_W-1:0]      mispredict_count
);

    typedef enum logic {IDLE, PEND} state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  redir_pc_q, redir_pc_d;
    logic [LW-1:0]    redir_lane_q, redir_lane_d;
    logic             flush_q, flush_d;

    logic [LANES-1:0] mis;
    logic             any_mis;
    logic [LW-1:0]    win_lane;
    logic [PC_W-1:0]  win_pc;

    // Descending scan so the lowest (oldest) mispredicting lane is the last one written.
    always_comb begin
        mis      = ex_valid & ex_is_branch & (ex_pred_taken ^ ex_taken);
        any_mis  = |mis;
        win_lane = '0;
        win_pc   = '0;
        for (int unsigned i = LANES; i > 0; i--) begin
            if (mis[i-1]) begin
                win_lane = LW'(i - 1);
                win_pc   = ex_taken[i-1] ? ex_target[(i-1)*PC_W +: PC_W]
                                         : ex_fallthru[(i-1)*PC_W +: PC_W];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        redir_pc_d   = redir_pc_q;
        redir_lane_d = redir_lane_q;
        flush_d      = 1'b0;
        kill_younger = '0;
        case (state_q)
            IDLE: begin
                if (any_mis) begin
                    state_d      = PEND;
                    redir_pc_d   = win_pc;
                    redir_lane_d = win_lane;
                    flush_d      = 1'b1;
                    for (int unsigned j = 0; j < LANES; j++) begin
                        kill_younger[j] = (LW'(j) > win_lane);
                    end
                end
            end
            PEND: begin
                if (redir_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            redir_pc_q   <= '0;
            redir_lane_q <= '0;
            flush_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            redir_pc_q   <= redir_pc_d;
            redir_lane_q <= redir_lane_d;
            flush_q      <= flush_d;
        end
    end

    assign redir_valid = (state_q == PEND);
    assign redir_pc    = redir_pc_q;
    assign redir_lane  = redir_lane_q;
    assign flush       = flush_q;

`ifdef BRU_STATS_EN
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (state_q == IDLE && any_mis && count_q != '1) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign mispredict_count = count_q;
`else
    assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Self-checking bench for branch_redirect_unit: directed scenarios then random traffic,
// all checked against a behavioural redirect model.
module tb_branch_redirect_unit;

    localparam int LANES = 2;
    localparam int PC_W  = 11;
    localparam int CNT_W = 2;
    localparam int LW    = 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [LANES-1:0]      ex_valid, ex_is_branch, ex_pred_taken, ex_taken;
    logic [LANES*PC_W-1:0] ex_fallthru, ex_target;
    logic                  redir_ready;
    logic [LANES-1:0]      kill_younger;
    logic                  redir_valid;
    logic [PC_W-1:0]       redir_pc;
    logic [LW-1:0]         redir_lane;
    logic                  flush;
    logic [CNT_W-1:0]      mispredict_count;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state
    bit              m_pend;
    logic [PC_W-1:0] m_pc;
    int              m_lane;
    bit              m_flush;
    int              m_cnt;

    branch_redirect_unit #(.LANES(LANES), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_pred_taken(ex_pred_taken), .ex_taken(ex_taken),
        .ex_fallthru(ex_fallthru), .ex_target(ex_target),
        .redir_ready(redir_ready), .kill_younger(kill_younger),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .redir_lane(redir_lane),
        .flush(flush), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_lane(input int i, input bit v, input bit br, input bit pred,
                            input bit tk, input int ft, input int tg);
        ex_valid[i]                  = v;
        ex_is_branch[i]              = br;
        ex_pred_taken[i]             = pred;
        ex_taken[i]                  = tk;
        ex_fallthru[i*PC_W +: PC_W]  = PC_W'(ft);
        ex_target[i*PC_W +: PC_W]    = PC_W'(tg);
    endtask

    task automatic clear_lanes();
        for (int i = 0; i < LANES; i++) set_lane(i, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock: check combinational kill, advance model on the edge, check registered outputs.
    task automatic step();
        int w;
        logic [LANES-1:0] ek;
        int exp_cnt;
        #1;
        w = -1;
        for (int i = 0; i < LANES; i++)
            if (w < 0 && ex_valid[i] && ex_is_branch[i] && (ex_pred_taken[i] != ex_taken[i]))
                w = i;
        ek = '0;
        if (!m_pend && w >= 0)
            for (int j = w + 1; j < LANES; j++) ek[j] = 1'b1;
        check("kill_younger", 32'(kill_younger), 32'(ek));
        @(posedge clk);
        if (rst) begin
            m_pend = 0; m_pc = '0; m_lane = 0; m_flush = 0; m_cnt = 0;
        end else if (!m_pend) begin
            m_flush = (w >= 0);
            if (w >= 0) begin
                m_pend = 1;
                m_lane = w;
                m_pc   = ex_taken[w] ? ex_target[w*PC_W +: PC_W] : ex_fallthru[w*PC_W +: PC_W];
                if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            end
        end else begin
            m_flush = 0;
            if (redir_ready) m_pend = 0;
        end
        @(negedge clk);
`ifdef BRU_STATS_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = 0;
`endif
        check("redir_valid", 32'(redir_valid), 32'(m_pend));
        check("redir_pc", 32'(redir_pc), 32'(m_pc));
        check("redir_lane", 32'(redir_lane), 32'(m_lane));
        check("flush", 32'(flush), 32'(m_flush));
        check("mispredict_count", 32'(mispredict_count), 32'(exp_cnt));
    endtask

    initial begin
        rst = 1'b1;
        redir_ready = 1'b1;
        ex_valid = '0; ex_is_branch = '0; ex_pred_taken = '0; ex_taken = '0;
        ex_fallthru = '0; ex_target = '0;
        m_pend = 0; m_pc = '0; m_lane = 0; m_flush = 0; m_cnt = 0;
        @(negedge clk);
        step();
        check("reset_valid", 32'(redir_valid), 32'd0);
        check("reset_pc", 32'(redir_pc), 32'd0);
        rst = 1'b0;

        // Lane 0 taken-mispredict, target 0x155
        clear_lanes();
        set_lane(0, 1, 1, 0, 1, 'h010, 'h155);
        set_lane(1, 1, 1, 0, 0, 'h020, 'h300);
        #1 check("t1_kill", 32'(kill_younger), 32'h2);
        step();
        check("t1_pc", 32'(redir_pc), 32'h155);
        check("t1_flush", 32'(flush), 32'd1);
        clear_lanes();
        step();
        check("t1_idle", 32'(redir_valid), 32'd0);

        // Lane 1 only, not-taken mispredict to fallthru 0x042
        set_lane(1, 1, 1, 1, 0, 'h042, 'h7f0);
        step();
        check("t2_pc", 32'(redir_pc), 32'h042);
        check("t2_lane", 32'(redir_lane), 32'd1);
        clear_lanes();
        step();

        // Both lanes mispredict: lane 0 wins
        set_lane(0, 1, 1, 1, 0, 'h111, 'h222);
        set_lane(1, 1, 1, 0, 1, 'h333, 'h444);
        step();
        check("t3_pc", 32'(redir_pc), 32'h111);
        check("t3_lane", 32'(redir_lane), 32'd0);

        // Fetch stalls three cycles while wrong-path mispredicts keep arriving
        redir_ready = 1'b0;
        set_lane(1, 1, 1, 0, 1, 'h555, 'h666);
        step();
        set_lane(0, 1, 1, 0, 1, 'h0aa, 'h0bb);
        step();
        step();
        check("t4_held_pc", 32'(redir_pc), 32'h111);
        redir_ready = 1'b1;
        step();
        check("t4_accept_idle", 32'(redir_valid), 32'd0);
        clear_lanes();
        step();

        // Non-mispredicting lanes
        set_lane(0, 1, 1, 1, 1, 'h001, 'h002);
        set_lane(1, 0, 1, 0, 1, 'h003, 'h004);
        step();
        set_lane(0, 1, 0, 0, 1, 'h005, 'h006);
        set_lane(1, 1, 0, 1, 0, 'h007, 'h008);
        step();
        check("t5_no_redirect", 32'(redir_valid), 32'd0);

        // Reset mid-PEND
        set_lane(0, 1, 1, 0, 1, 'h123, 'h456);
        redir_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        check("t6_rst_valid", 32'(redir_valid), 32'd0);
        check("t6_rst_flush", 32'(flush), 32'd0);
        rst = 1'b0;
        redir_ready = 1'b1;

        // Four accepted mispredicts saturate a 2-bit counter
        for (int k = 0; k < 4; k++) begin
            clear_lanes();
            set_lane(k % 2, 1, 1, 1, 0, 'h100 + k, 'h200 + k);
            step();
            clear_lanes();
            step();
        end
`ifdef BRU_STATS_EN
        check("t7_sat", 32'(mispredict_count), 32'd3);
`else
        check("t7_tied", 32'(mispredict_count), 32'd0);
`endif

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < LANES; i++)
                set_lane(i, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                         1'($urandom), 1'($urandom),
                         int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)));
            redir_ready = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 39) == 0);
            step();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
